// File: rtl/edge_capture_pkg.sv
// Shared defaults and types for the edge-capture register block.
package edge_capture_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;

    typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/edge_capture_reg_sync_chain.sv
// One-bit multi-flop synchroniser for an asynchronous input.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the raw bit through the chain every clock; reset flushes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_r <= {STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/edge_capture_reg.sv
// Synchronises an input vector, registers it under enable and reports
// per-bit rise/fall pulses plus a saturating count of edge-event cycles.
module edge_capture_reg
    import edge_capture_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = $bits(cnt_t)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic             any_r;
    logic [CNT_W-1:0] cnt_r;
    logic             event_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sync
        sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (d[i]),
            .q     (sync_s[i])
        );
    end

    // An event cycle is one where the captured value would change,
    // however many bits move.
    assign event_s = en && (sync_s != q_r);

    // Capture register and edge pulses; pulses compare against the old q.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r    <= {WIDTH{1'b0}};
            rise_r <= {WIDTH{1'b0}};
            fall_r <= {WIDTH{1'b0}};
            any_r  <= 1'b0;
        end else if (en) begin
            q_r    <= sync_s;
            rise_r <= sync_s & ~q_r;
            fall_r <= ~sync_s & q_r;
            any_r  <= event_s;
        end else begin
            q_r    <= q_r;
            rise_r <= {WIDTH{1'b0}};
            fall_r <= {WIDTH{1'b0}};
            any_r  <= 1'b0;
        end
    end

    // Saturating event counter; clear wins over a coincident event.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (event_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign q        = q_r;
    assign rise     = rise_r;
    assign fall     = fall_r;
    assign any_edge = any_r;
    assign edge_cnt = cnt_r;
    assign cnt_sat  = (cnt_r == CNT_MAX);

endmodule

// File: tb/tb_edge_capture_reg.sv
// Randomised and directed bench for edge_capture_reg against a queue-based reference model.
module tb_edge_capture_reg;
    import edge_capture_pkg::*;

    localparam int W  = 8;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         clr_cnt;
    logic [W-1:0] d;

    logic [W-1:0] q, rise, fall, q2, rise2, fall2;
    logic         any_edge, any2, cnt_sat, cnt_sat2;
    cnt_t         edge_cnt;
    logic [1:0]   edge_cnt2;

    int n_pass = 0;
    int n_total = 0;

    logic [W-1:0] m_pipe[$];
    logic [W-1:0] m_q, m_rise, m_fall;
    logic         m_any;
    int           m_events;

    always #5 clk = ~clk;

    edge_capture_reg #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .en(en), .d(d), .clr_cnt(clr_cnt),
        .q(q), .rise(rise), .fall(fall), .any_edge(any_edge),
        .edge_cnt(edge_cnt), .cnt_sat(cnt_sat)
    );

    edge_capture_reg #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .d(d), .clr_cnt(clr_cnt),
        .q(q2), .rise(rise2), .fall(fall2), .any_edge(any2),
        .edge_cnt(edge_cnt2), .cnt_sat(cnt_sat2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, then compare.
    task automatic step();
        logic [W-1:0] s;
        int e16, e2;
        @(posedge clk);
        s = m_pipe[SS-1];
        if (reset) begin
            for (int i = 0; i < SS; i++) m_pipe[i] = '0;
            m_q = '0; m_rise = '0; m_fall = '0; m_any = 1'b0; m_events = 0;
        end else begin
            if (en) begin
                m_rise = s & ~m_q;
                m_fall = ~s & m_q;
                m_any  = (s != m_q);
                if (clr_cnt) m_events = 0;
                else if (s != m_q) m_events++;
                m_q = s;
            end else begin
                m_rise = '0; m_fall = '0; m_any = 1'b0;
                if (clr_cnt) m_events = 0;
            end
            m_pipe.push_front(d);
            void'(m_pipe.pop_back());
        end
        e16 = (m_events > 65535) ? 65535 : m_events;
        e2  = (m_events > 3) ? 3 : m_events;
        #1;
        check_val("q",        32'(q),        32'(m_q));
        check_val("rise",     32'(rise),     32'(m_rise));
        check_val("fall",     32'(fall),     32'(m_fall));
        check_val("any_edge", 32'(any_edge), 32'(m_any));
        check_val("edge_cnt", 32'(edge_cnt), 32'(e16));
        check_val("cnt_sat",  32'(cnt_sat),  32'(e16 == 65535));
        check_val("q_w2",     32'(q2),       32'(m_q));
        check_val("rise_w2",  32'(rise2),    32'(m_rise));
        check_val("fall_w2",  32'(fall2),    32'(m_fall));
        check_val("any_w2",   32'(any2),     32'(m_any));
        check_val("cnt_w2",   32'(edge_cnt2), 32'(e2));
        check_val("sat_w2",   32'(cnt_sat2), 32'(e2 == 3));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int i = 0; i < SS; i++) m_pipe.push_back('0);
        m_q = '0; m_rise = '0; m_fall = '0; m_any = 1'b0; m_events = 0;
        reset = 1'b1; en = 1'b1; clr_cnt = 1'b0; d = '0;
        steps(3);
        reset = 1'b0;
        steps(3);

        // single rising bit, three-clock latency
        d = 8'h01; steps(5);
        // 0xFF -> 0x0F: four falling bits, one counted event
        d = 8'hFF; steps(5);
        d = 8'h0F; steps(5);
        // disabled capture holds q, then releases the pending value
        d = 8'h00; steps(5);
        en = 1'b0; d = 8'hAA; steps(5);
        en = 1'b1; steps(3);
        // saturation of the narrow counter over five events
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d = (k % 2 == 0) ? 8'h55 : 8'hAA;
            steps(3);
        end
        // clear coincident with an event
        d = 8'h10; steps(2);
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        steps(2);
        // reset mid-toggle with d held high
        d = 8'h00; steps(3);
        d = 8'hFF; step();
        reset = 1'b1; steps(2);
        reset = 1'b0; steps(5);

        // randomised phase
        for (int n = 0; n < 2000; n++) begin
            d       = W'($urandom);
            en      = ($urandom_range(0, 3) != 0);
            clr_cnt = ($urandom_range(0, 15) == 0);
            reset   = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
